// File: rtl/pattern_scan_ctrl_if.sv
// Scan request/result bundle for pattern_scan_ctrl.
// master drives start/din/abort; slave returns busy/done/found/hits/first_idx.
interface pattern_scan_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             abort;
  logic             busy;
  logic             done;
  logic             found;
  logic [CNT_W-1:0] hits;
  logic [3:0]       first_idx;

  modport master (
    output start, din, abort,
    input  busy, done, found, hits, first_idx
  );

  modport slave (
    input  start, din, abort,
    output busy, done, found, hits, first_idx
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Scans one WIDTH-bit word MSB first for 1101; counts hits, first hit index.
// Ports: clk, reset (async active-low), bus (slave). Macro OVERLAP_EN: overlap.
module pattern_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  pattern_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    D_ST    = 3'd0,
    D_1     = 3'd1,
    D_11    = 3'd2,
    D_110   = 3'd3,
    D_1101  = 3'd4
  } det_t;

  localparam logic [3:0] LAST = 4'(WIDTH - 1);

  state_t           state_q, state_d;
  det_t             det_q, det_d, det_nxt;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic             found_q, found_d;
  logic [3:0]       first_q, first_d;
  logic             x;
  logic             start_ok, abort_ok, shift_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      det_q   <= D_ST;
      shreg_q <= '0;
      idx_q   <= '0;
      hits_q  <= '0;
      found_q <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      hits_q  <= hits_d;
      found_q <= found_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT: begin
        if (bus.abort)          state_d = IDLE;
        else if (idx_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == SHIFT);
    bus.done = (state_q == DONE);
  end

  assign bus.found     = found_q;
  assign bus.hits      = hits_q;
  assign bus.first_idx = first_q;

  assign x = shreg_q[WIDTH-1];

  always_comb begin
    det_nxt = D_ST;
    unique case (det_q)
      D_ST:    det_nxt = x ? D_1    : D_ST;
      D_1:     det_nxt = x ? D_11   : D_ST;
      D_11:    det_nxt = x ? D_11   : D_110;
      D_110:   det_nxt = x ? D_1101 : D_ST;
`ifdef OVERLAP_EN
      D_1101:  det_nxt = x ? D_11   : D_ST;
`else
      D_1101:  det_nxt = x ? D_1    : D_ST;
`endif
      default: det_nxt = D_ST;
    endcase
  end

  assign start_ok = (state_q == IDLE) && bus.start;
  assign abort_ok = (state_q == SHIFT) && bus.abort;
  assign shift_ok = (state_q == SHIFT) && !bus.abort;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    det_d   = det_q;
    hits_d  = hits_q;
    found_d = found_q;
    first_d = first_q;
    unique case (1'b1)
      start_ok: begin
        shreg_d = bus.din;
        idx_d   = '0;
        det_d   = D_ST;
        hits_d  = '0;
        found_d = 1'b0;
        first_d = '0;
      end
      abort_ok: begin
        det_d   = D_ST;
        hits_d  = '0;
        found_d = 1'b0;
        first_d = '0;
      end
      shift_ok: begin
        shreg_d = shreg_q << 1;
        idx_d   = idx_q + 4'd1;
        det_d   = det_nxt;
        if (det_nxt == D_1101) begin
          if (!(&hits_q)) hits_d = hits_q + 1'b1;
          if (!found_q) begin
            found_d = 1'b1;
            first_d = idx_q;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl.
// Covers reset, scans, saturation-free cases, abort, held start, async reset.
module tb_pattern_scan_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pattern_scan_ctrl_if #(.WIDTH(8), .CNT_W(4)) bus ();

  pattern_scan_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef OVERLAP_EN
  localparam int H_A = 2;
  localparam int H_B = 2;
`else
  localparam int H_A = 1;
  localparam int H_B = 1;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [7:0] d, input string tag);
    int bc;
    int dc;
    bus.din   = d;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy0"}, bus.busy, 1);
    bc = 0;
    dc = 0;
    for (int i = 1; i < 8; i++) begin
      tick();
      bc += bus.busy;
      dc += bus.done;
    end
    chk({tag, "_bc"}, bc, 7);
    chk({tag, "_dc"}, dc, 0);
    tick();
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_nbusy"}, bus.busy, 0);
    tick();
    chk({tag, "_done1w"}, bus.done, 0);
  endtask

  initial begin
    int dc;
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.din   = '0;
    bus.abort = 1'b0;
    #23;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_found", bus.found, 0);
    chk("rst_hits", bus.hits, 0);
    chk("rst_first", bus.first_idx, 0);
    reset = 1'b1;
    tick();

    scan(8'b11011011, "a");
    chk("a_hits", bus.hits, H_A);
    chk("a_found", bus.found, 1);
    chk("a_first", bus.first_idx, 3);
    bus.abort = 1'b1;
    tick();
    tick();
    tick();
    bus.abort = 1'b0;
    chk("a_hold_hits", bus.hits, H_A);
    chk("a_hold_first", bus.first_idx, 3);

    scan(8'b00000000, "z");
    chk("z_hits", bus.hits, 0);
    chk("z_found", bus.found, 0);
    chk("z_first", bus.first_idx, 0);

    scan(8'b11111111, "o");
    chk("o_hits", bus.hits, 0);
    chk("o_found", bus.found, 0);
    chk("o_first", bus.first_idx, 0);

    // abort while bit 4 is pending
    bus.din   = 8'b11011011;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    chk("ab_pre_found", bus.found, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_busy", bus.busy, 0);
    chk("ab_hits", bus.hits, 0);
    chk("ab_found", bus.found, 0);
    chk("ab_first", bus.first_idx, 0);
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      dc += bus.done;
    end
    chk("ab_nodone", dc, 0);

    // start held high across a full scan
    bus.din   = 8'b00001101;
    bus.start = 1'b1;
    tick();
    chk("hs_busy0", bus.busy, 1);
    for (int i = 1; i < 8; i++) tick();
    chk("hs_busy7", bus.busy, 1);
    tick();
    chk("hs_done", bus.done, 1);
    chk("hs_hits", bus.hits, 1);
    chk("hs_first", bus.first_idx, 7);
    tick();
    chk("hs_idle", bus.busy, 0);
    tick();
    chk("hs_rebusy", bus.busy, 1);
    chk("hs_clr", bus.hits, 0);
    bus.start = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    tick();
    chk("hs2_done", bus.done, 1);
    chk("hs2_hits", bus.hits, 1);
    tick();

    // async reset mid-scan, between edges
    bus.din   = 8'b11011011;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    chk("ar_pre_busy", bus.busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_busy", bus.busy, 0);
    chk("ar_done", bus.done, 0);
    chk("ar_found", bus.found, 0);
    chk("ar_hits", bus.hits, 0);
    chk("ar_first", bus.first_idx, 0);
    #3;
    reset = 1'b1;
    tick();
    scan(8'b01101101, "b");
    chk("b_hits", bus.hits, H_B);
    chk("b_found", bus.found, 1);
    chk("b_first", bus.first_idx, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of bits in one scan word (legal range 4..16).
REQ-002 SHALL have parameter CNT_W, default 4: width of the hit counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to scan the word on din.
REQ-006 SHALL have port din, input, WIDTH bits: word to scan, captured when start is accepted.
REQ-007 SHALL have port abort, input, 1 bit: cancels a scan in progress.
REQ-008 SHALL have port busy, output, 1 bit: high while bits are being shifted.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a scan completes.
REQ-010 SHALL have port found, output, 1 bit: at least one 1101 match in the last completed scan.
REQ-011 SHALL have port hits, output, CNT_W bits: number of 1101 matches in the last scan.
REQ-012 SHALL have port first_idx, output, 4 bits: bit index of the final '1' of the first match.

Function
REQ-013 SHALL implement controller states IDLE, SHIFT and DONE.
REQ-014 SHALL, in IDLE with start=1 at a rising edge, perform the following: capture din, clear hits/found/first_idx, reset the embedded detector to its start state, and enter SHIFT.
REQ-015 SHALL ignore start while in SHIFT or DONE; no queuing.
REQ-016 SHALL feed one bit per SHIFT cycle into an embedded Moore 1101 detector (states start, id1, id11, id110, id1101), MSB first; bit index 0 = din[WIDTH-1].
REQ-017 SHALL use these detector transitions (x = current bit):
- start: x=1 -> id1, x=0 -> start.
- id1: x=1 -> id11, x=0 -> start.
- id11: x=1 -> id11, x=0 -> id110.
- id110: x=1 -> id1101, x=0 -> start.
- id1101: behaviour per REQ-029/030.
REQ-018 SHALL count a hit on each edge at which the detector enters id1101.
REQ-019 SHALL make hits saturate at 2^CNT_W-1; no wrap-around.
REQ-020 SHALL, on the first hit of a scan, load first_idx with the current bit index and set found; later hits leave both unchanged.
REQ-021 SHALL, after bit index WIDTH-1 is processed, enter DONE; done=1 for exactly that one cycle, then return to IDLE.
REQ-022 SHALL give latency as follows: start accepted at edge 0 -> busy=1 for cycles after edges 0..WIDTH-1 -> done=1 after edge WIDTH -> IDLE after edge WIDTH+1.
REQ-023 SHALL hold hits, found and first_idx stable from DONE until the next accepted start.
REQ-024 SHALL make abort=1 in SHIFT return to IDLE at the next edge, with no done pulse and hits/found/first_idx cleared; abort is ignored in IDLE and DONE.
REQ-025 SHALL drive busy=1 only in SHIFT and done=1 only in DONE, both decoded from registered state, with no combinational path from inputs.

Reset
REQ-026 SHALL, while reset=0, force IDLE and detector start state immediately, regardless of clk.
REQ-027 SHALL make reset values busy=0, done=0, found=0, hits=0 and first_idx=0.
REQ-028 SHALL, when reset is asserted mid-scan, discard the scan; after release, the first accepted start behaves per REQ-014.

Configuration
REQ-029 SHALL, with OVERLAP_EN defined, allow overlapping matches: id1101 goes to id11 on x=1 and to start on x=0.
REQ-030 SHALL, without OVERLAP_EN defined, make matches non-overlapping: id1101 goes to id1 on x=1 and to start on x=0.

Verification
REQ-031 SHALL cover: OVERLAP_EN defined, din=8'b11011011, start pulse -> done after edge 8, hits=2, found=1, first_idx=3.
REQ-032 SHALL cover: OVERLAP_EN undefined, din=8'b11011011 -> hits=1, found=1, first_idx=3.
REQ-033 SHALL cover: din=8'b00000000, and separately din=8'b11111111 -> hits=0, found=0, first_idx=0, done pulse width 1 cycle.
REQ-034 SHALL cover: start held high through a whole scan -> second scan begins only at the first edge in IDLE after DONE; no start accepted while busy=1.
REQ-035 SHALL cover: abort=1 at bit index 4 of din=8'b11011011 -> IDLE next edge, done never pulses, hits=0, found=0.
REQ-036 SHALL cover: reset=0 asynchronously between clock edges at bit index 5 -> busy=0 and all outputs 0 immediately; a new scan of 8'b01101101 with OVERLAP_EN defined -> hits=2, first_idx=4.
